axi_lite_prio_irq_ctrl: RTL and testbench
=========================================

// Module: axi_lite_prio_irq_ctrl
// PURPOSE
//  Parametrised AXI4-Lite interrupt controller: NUM_IRQ sources, per-source priority, per-source edge/level
//  mode, software trigger, W1C pending, acknowledge-based service. Sits behind the AXI interconnect as a
//  memory-mapped slave; drives one level CPU interrupt line plus the winning source id.
// PARAMETERS
//  NUM_IRQ  8  number of sources, 1..32
//  PRIO_W   3  priority field width; priority 0 = never serviced
//  ADDR_W   8  AXI address width (byte address, low 2 bits ignored)
// PORTS
//  aclk           in   1        clock
//  aresetn        in   1        asynchronous active-low reset
//  s_axi_awaddr   in   ADDR_W   write address;  s_axi_awvalid in 1 / s_axi_awready out 1
//  s_axi_wdata    in   32       write data; s_axi_wstrb in 4; s_axi_wvalid in 1 / s_axi_wready out 1
//  s_axi_bresp    out  2        OKAY=00, SLVERR=10;  s_axi_bvalid out 1 / s_axi_bready in 1
//  s_axi_araddr   in   ADDR_W   read address;   s_axi_arvalid in 1 / s_axi_arready out 1
//  s_axi_rdata    out  32       read data; s_axi_rresp out 2; s_axi_rvalid out 1 / s_axi_rready in 1
//  irq_in         in   NUM_IRQ  source lines, synchronous to aclk
//  irq            out  1        CPU interrupt, level, high while a source is in service and GIE=1
//  irq_id         out  ID_W     in-service source index, ID_W = max(1,clog2(NUM_IRQ))
// BEHAVIOUR
//  Reset: all registers 0, FSM IDLE; irq=0, irq_id=0, all ready/valid outputs 0, bresp/rresp/rdata=0.
//  Register map: 0x00 CSR: b0 GIE rw, b1 ACK w1 self-clearing (reads 0), b8 IN_SERVICE ro.
//   0x04 MASK rw; 0x08 MODE rw (1=edge,0=level); 0x0C SWTRIG w1 (reads 0); 0x10 PENDING ro, w1c;
//   0x14 ACTIVE ro = {IN_SERVICE,irq_id}; 0x40+4*k PRIO[k] rw, bits[PRIO_W-1:0], k<NUM_IRQ.
//   Bits >= NUM_IRQ read 0, writes ignored. Unmapped address: write dropped, read 0, resp SLVERR.
//  AXI write: AW and W accepted independently (ready high while slot empty, one transaction in flight);
//   register update on the cycle both are held; bvalid next cycle, held until bready. wstrb per byte.
//  AXI read: arready high when no read outstanding; rvalid one cycle after AR handshake, held until rready.
//  Pending[k]: edge mode: set on irq_in rising (registered prior sample) or SWTRIG bit k; cleared by W1C
//   or by ACK of k. Level mode: irq_in[k] | swlat[k]; swlat set by SWTRIG, cleared by ACK of k; W1C clears swlat.
//  Eligible[k] = pending & MASK & (PRIO!=0). Winner = max PRIO; tie -> lowest index.
//  FSM IDLE: if GIE and any eligible -> SERVICE, latch winner into irq_id. irq=1 from the second rising
//   edge after irq_in rise is sampled (edge N: pending set; edge N+1: SERVICE).
//  SERVICE: no preemption; ACK -> IDLE, clear edge pending/swlat of irq_id; re-arbitrate next cycle.
//   GIE=0 while SERVICE: irq=0, state kept; irq returns when GIE=1. MASK/PRIO/W1C changes do not abort.
//  ACK in IDLE ignored. Simultaneous set and clear of the same pending bit (edge vs W1C/ACK): set wins.
//  Level source still high after ACK: re-serviced after one IDLE cycle.
//  aresetn low mid-transaction: immediate clear, in-flight AXI transfers dropped, no response issued.
// TESTING
//  1 Reset: aresetn=0 175ns -> irq=0, reads of 0x00..0x14 return 0, PRIO[0..7]=0, all resp OKAY.
//  2 MASK=0x1B, MODE=0xFF, PRIO[0]=1,PRIO[3]=4,PRIO[4]=4, CSR=1; pulse irq_in=0x19 one cycle
//    -> irq_id=3 (tie 3/4 -> lower); ACK -> irq_id=4; ACK -> irq_id=0; ACK -> irq=0, PENDING=0.
//  3 MODE=0 source 2 PRIO=7 MASK=0x4 GIE=1, hold irq_in[2]=1 -> ACK -> irq drops one cycle, reasserts
//    irq_id=2; drop irq_in[2], ACK -> irq stays 0.
//  4 SWTRIG=0x20 with MASK=0, PRIO[5]=2 -> PENDING=0x20, irq=0; MASK=0x20 -> irq=1,id=5; W1C 0x10=0x20 -> PENDING=0.
//  5 Write 0x30, read 0xFC -> bresp=SLVERR, rresp=SLVERR, rdata=0; AW and W 3 cycles apart -> single B;
//    bready held low 5 cycles -> bvalid held, no new AW accepted.
//  6 Edge on irq_in[1] same cycle as W1C of bit1 -> PENDING[1]=1; aresetn=0 during SERVICE -> irq=0 immediately.

Source files
------------

// File: rtl/axi_lite_prio_irq_ctrl.sv
// AXI4-Lite interrupt controller: prioritised, maskable sources with edge/level
// modes, software trigger, W1C pending and acknowledge-based service.
module axi_lite_prio_irq_ctrl #(
    parameter  int NUM_IRQ = 8,
    parameter  int PRIO_W  = 3,
    parameter  int ADDR_W  = 8,
    localparam int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [ADDR_W-1:0]  s_axi_awaddr,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [31:0]        s_axi_wdata,
    input  logic [3:0]         s_axi_wstrb,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    output logic [1:0]         s_axi_bresp,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    input  logic [ADDR_W-1:0]  s_axi_araddr,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    output logic [31:0]        s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id
);

    localparam int AW2 = ADDR_W - 2;
    localparam logic [AW2-1:0] W_CSR      = AW2'(0);
    localparam logic [AW2-1:0] W_MASK     = AW2'(1);
    localparam logic [AW2-1:0] W_MODE     = AW2'(2);
    localparam logic [AW2-1:0] W_SWTRIG   = AW2'(3);
    localparam logic [AW2-1:0] W_PEND     = AW2'(4);
    localparam logic [AW2-1:0] W_ACTIVE   = AW2'(5);
    localparam logic [AW2-1:0] W_PRIO     = AW2'(16);
    localparam logic [AW2-1:0] W_PRIO_END = AW2'(16 + NUM_IRQ);
    localparam logic [1:0]     RESP_OKAY  = 2'b00;
    localparam logic [1:0]     RESP_SLV   = 2'b10;

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t               state, state_nxt;
    logic                 rdy_en;
    logic                 aw_full, w_full;
    logic [AW2-1:0]       aw_word;
    logic [31:0]          wdata_q;
    logic [3:0]           wstrb_q;
    logic                 gie;
    logic [NUM_IRQ-1:0]   mask, mode, pend_edge, swlat, irq_prev;
    logic [PRIO_W-1:0]    prio [NUM_IRQ];
    logic [ID_W-1:0]      id_q;

    logic                 wr_fire, wr_ok, ack;
    logic [31:0]          wbits, mask_m, mode_m, rd_val;
    logic [NUM_IRQ-1:0]   sw_set, w1c, ack_clr, clr, rise, pend_vis, elig;
    logic [NUM_IRQ-1:0]   pend_edge_nxt, swlat_nxt;
    logic [PRIO_W-1:0]    win_prio;
    logic [ID_W-1:0]      win_id;
    logic [AW2-1:0]       rd_word;
    logic                 in_svc;
    logic                 unused_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    function automatic logic is_mapped(input logic [AW2-1:0] w);
        return (w <= W_ACTIVE) || ((w >= W_PRIO) && (w < W_PRIO_END));
    endfunction

    assign in_svc        = (state == SERVICE);
    assign irq           = in_svc & gie;
    assign irq_id        = id_q;
    // One write and one read in flight; nothing is accepted until its response retires.
    assign s_axi_awready = rdy_en & ~aw_full & ~s_axi_bvalid;
    assign s_axi_wready  = rdy_en & ~w_full & ~s_axi_bvalid;
    assign s_axi_arready = rdy_en & ~s_axi_rvalid;
    assign wr_fire       = aw_full & w_full;
    assign wr_ok         = wr_fire & is_mapped(aw_word);
    assign rd_word       = s_axi_araddr[ADDR_W-1:2];
    assign unused_bits   = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], wbits, mask_m, mode_m};

    always_comb begin
        wbits   = merge_bytes(32'd0, wdata_q, wstrb_q);
        mask_m  = merge_bytes(32'(mask), wdata_q, wstrb_q);
        mode_m  = merge_bytes(32'(mode), wdata_q, wstrb_q);
        ack     = wr_ok && (aw_word == W_CSR) && wbits[1] && in_svc;
        sw_set  = (wr_ok && (aw_word == W_SWTRIG)) ? wbits[NUM_IRQ-1:0] : '0;
        w1c     = (wr_ok && (aw_word == W_PEND)) ? wbits[NUM_IRQ-1:0] : '0;
        ack_clr = ack ? (NUM_IRQ'(1) << id_q) : '0;
        clr     = w1c | ack_clr;
        rise    = irq_in & ~irq_prev;
        // Sets are OR-ed after clears so a coincident edge survives W1C/ACK.
        pend_edge_nxt = (pend_edge & ~clr) | (mode & (rise | sw_set));
        swlat_nxt     = (swlat & ~clr) | (~mode & sw_set);
        pend_vis      = (mode & pend_edge) | (~mode & (irq_in | swlat));
    end

    // Strict '>' keeps the lowest index on priority ties.
    always_comb begin
        win_prio = '0;
        win_id   = '0;
        elig     = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            elig[k] = pend_vis[k] & mask[k] & (prio[k] != '0);
            if (elig[k] && (prio[k] > win_prio)) begin
                win_prio = prio[k];
                win_id   = ID_W'(k);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gie && (win_prio != '0)) state_nxt = SERVICE;
            SERVICE: if (ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (rd_word)
            W_CSR:    rd_val = {23'd0, in_svc, 7'd0, gie};
            W_MASK:   rd_val = 32'(mask);
            W_MODE:   rd_val = 32'(mode);
            W_PEND:   rd_val = 32'(pend_vis);
            W_ACTIVE: rd_val = 32'({in_svc, id_q});
            default: begin
                for (int k = 0; k < NUM_IRQ; k++)
                    if (rd_word == (W_PRIO + AW2'(k))) rd_val = 32'(prio[k]);
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            id_q      <= '0;
            rdy_en    <= 1'b0;
            gie       <= 1'b0;
            mask      <= '0;
            mode      <= '0;
            pend_edge <= '0;
            swlat     <= '0;
            irq_prev  <= '0;
            for (int k = 0; k < NUM_IRQ; k++) prio[k] <= '0;
        end else begin
            state     <= state_nxt;
            rdy_en    <= 1'b1;
            pend_edge <= pend_edge_nxt;
            swlat     <= swlat_nxt;
            irq_prev  <= irq_in;
            if ((state == IDLE) && (state_nxt == SERVICE)) id_q <= win_id;
            if (wr_ok) begin
                if ((aw_word == W_CSR) && wstrb_q[0]) gie <= wdata_q[0];
                if (aw_word == W_MASK) mask <= mask_m[NUM_IRQ-1:0];
                if (aw_word == W_MODE) mode <= mode_m[NUM_IRQ-1:0];
                for (int k = 0; k < NUM_IRQ; k++)
                    if ((aw_word == (W_PRIO + AW2'(k))) && wstrb_q[0]) prio[k] <= wdata_q[PRIO_W-1:0];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_word      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_full <= 1'b1;
                aw_word <= s_axi_awaddr[ADDR_W-1:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_full  <= 1'b1;
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (wr_fire) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= is_mapped(aw_word) ? RESP_OKAY : RESP_SLV;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            if (s_axi_arvalid && s_axi_arready) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_val;
                s_axi_rresp  <= is_mapped(rd_word) ? RESP_OKAY : RESP_SLV;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_prio_irq_ctrl.sv
// Scoreboard bench for axi_lite_prio_irq_ctrl: directed scenarios plus random
// traffic checked against a register-level behavioural model.
module tb_axi_lite_prio_irq_ctrl;

    localparam int N = 8;

    logic        aclk = 1'b1;
    logic        aresetn = 1'b0;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic [N-1:0] irq_in = '0;
    logic [2:0]  irq_id;

    axi_lite_prio_irq_ctrl #(.NUM_IRQ(N), .PRIO_W(3), .ADDR_W(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .irq_in(irq_in), .irq(irq), .irq_id(irq_id)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0, n_fail = 0, b_cnt = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    // Reference model state
    bit          m_gie, m_svc;
    int          m_id;
    bit [31:0]   m_mask, m_mode, m_pe, m_sl, m_prev;
    int          m_prio[N];
    bit          cw_v = 0;
    int          cw_a;
    bit [31:0]   cw_d;
    bit [3:0]    cw_s;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_gie = 0; m_svc = 0; m_id = 0;
        m_mask = 0; m_mode = 0; m_pe = 0; m_sl = 0; m_prev = 0;
        for (int k = 0; k < N; k++) m_prio[k] = 0;
    endfunction

    function automatic bit [31:0] model_pending(input bit [31:0] in_now);
        bit [31:0] v = 0;
        for (int k = 0; k < N; k++) v[k] = m_mode[k] ? m_pe[k] : (in_now[k] | m_sl[k]);
        return v;
    endfunction

    function automatic bit is_reg(input int a);
        int w = (a >> 2) & 63;
        return (w <= 5) || (w >= 16 && w < 16 + N);
    endfunction

    // One clock edge of the controller as described by its register-level rules.
    function automatic void model_edge(input bit [31:0] in_now);
        bit [31:0] vis, bm, wb, clr, sw, rise, allm;
        int best = 0, bid = 0, w = -1;
        bit ack = 0;
        allm = (32'd1 << N) - 1;
        vis = model_pending(in_now);
        for (int k = 0; k < N; k++)
            if (vis[k] && m_mask[k] && m_prio[k] > best) begin best = m_prio[k]; bid = k; end
        sw = 0; clr = 0; bm = 0; wb = 0;
        if (cw_v && is_reg(cw_a)) begin
            bm = {{8{cw_s[3]}}, {8{cw_s[2]}}, {8{cw_s[1]}}, {8{cw_s[0]}}};
            wb = cw_d & bm & 32'hFFFF_FFFF;
            w  = (cw_a >> 2) & 63;
            if (w == 0 && wb[1] && m_svc) ack = 1;
            if (w == 3) sw = wb & allm;
            if (w == 4) clr = wb & allm;
        end
        if (ack) clr[m_id] = 1;
        rise = in_now & ~m_prev;
        if (!m_svc) begin
            if (m_gie && best > 0) begin m_svc = 1; m_id = bid; end
        end else if (ack) m_svc = 0;
        m_pe = (m_pe & ~clr) | (m_mode & (rise | sw));
        m_sl = (m_sl & ~clr) | (~m_mode & allm & sw);
        if (w == 0 && cw_s[0]) m_gie = cw_d[0];
        if (w == 1) m_mask = ((m_mask & ~bm) | wb) & allm;
        if (w == 2) m_mode = ((m_mode & ~bm) | wb) & allm;
        if (w >= 16 && w < 16 + N && cw_s[0]) m_prio[w-16] = cw_d & 7;
        m_prev = in_now;
    endfunction

    function automatic bit [31:0] model_read(input int a, input bit [31:0] in_now);
        int w = (a >> 2) & 63;
        if (w == 0) return (32'(m_svc) << 8) | 32'(m_gie);
        if (w == 1) return m_mask;
        if (w == 2) return m_mode;
        if (w == 4) return model_pending(in_now);
        if (w == 5) return (32'(m_svc) << 3) | 32'(m_id);
        if (w >= 16 && w < 16 + N) return 32'(m_prio[w-16]);
        return 0;
    endfunction

    task automatic tick();
        bit [31:0] snap;
        snap = 32'(irq_in);
        @(posedge aclk);
        if (aresetn) model_edge(snap);
        #1;
    endtask

    task automatic wait_ready(input bit is_w);
        int n = 0;
        while (!(is_w ? (awready && wready) : arready) && n < 50) begin tick(); n++; end
        if (n >= 50) chk(is_w ? "aw_w_ready_timeout" : "ar_ready_timeout", 0, 1);
    endtask

    task automatic axi_write(input int a, input bit [31:0] d, input bit [3:0] s, input int in_at_commit);
        wait_ready(1);
        awaddr = 8'(a); wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        bq.push_back(is_reg(a) ? 2'b00 : 2'b10);
        tick();
        awvalid = 0; wvalid = 0;
        if (in_at_commit >= 0) irq_in = N'(in_at_commit);
        cw_v = 1; cw_a = a; cw_d = d; cw_s = s;
        tick();
        cw_v = 0;
        tick();
    endtask

    task automatic axi_read(input int a);
        wait_ready(0);
        araddr = 8'(a); arvalid = 1;
        rq.push_back({(is_reg(a) ? 2'b00 : 2'b10), model_read(a, 32'(irq_in))});
        tick();
        arvalid = 0;
        tick();
    endtask

    always @(negedge aclk) begin
        logic [33:0] er;
        if (bvalid && bready) begin
            b_cnt++;
            if (bq.size() == 0) chk("unexpected_b", 1, 0);
            else chk("bresp", bresp, bq.pop_front());
        end
        if (rvalid && rready) begin
            if (rq.size() == 0) chk("unexpected_r", 1, 0);
            else begin
                er = rq.pop_front();
                chk("rdata", rdata, er[31:0]);
                chk("rresp", rresp, er[33:32]);
            end
        end
        chk("irq", irq, m_svc & m_gie);
        chk("irq_id", irq_id, m_id);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        model_reset();
        // Reset state
        #100;
        chk("rst_irq", irq, 0);        chk("rst_irq_id", irq_id, 0);
        chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0); chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);   chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);     chk("rst_rdata", rdata, 0);
        #75 aresetn = 1;
        for (int a = 0; a <= 'h14; a += 4) axi_read(a);
        for (int k = 0; k < N; k++) axi_read('h40 + 4*k);

        // Edge sources, priority tie and ACK chain
        axi_write('h04, 'h1B, 4'hF, -1);
        axi_write('h08, 'hFF, 4'hF, -1);
        axi_write('h40, 1, 4'hF, -1);
        axi_write('h4C, 4, 4'hF, -1);
        axi_write('h50, 4, 4'hF, -1);
        axi_write('h00, 1, 4'hF, -1);
        irq_in = 8'h19; tick();
        irq_in = 8'h00; tick();
        chk("t2_irq", irq, 1); chk("t2_id3", irq_id, 3);
        axi_write('h00, 3, 4'hF, -1); chk("t2_id4", irq_id, 4);
        axi_write('h00, 3, 4'hF, -1); chk("t2_id0", irq_id, 0); chk("t2_irq_id0", irq, 1);
        axi_write('h00, 3, 4'hF, -1); chk("t2_irq_off", irq, 0);
        axi_read('h10);

        // Level source re-service
        axi_write('h08, 0, 4'hF, -1);
        axi_write('h48, 7, 4'hF, -1);
        axi_write('h04, 4, 4'hF, -1);
        irq_in = 8'h04; tick(); tick();
        chk("t3_irq", irq, 1); chk("t3_id2", irq_id, 2);
        axi_write('h00, 3, 4'hF, -1); chk("t3_reassert", irq, 1); chk("t3_id2b", irq_id, 2);
        irq_in = 8'h00;
        axi_write('h00, 3, 4'hF, -1); tick(); tick(); chk("t3_irq_off", irq, 0);

        // Software trigger gated by mask, then W1C
        axi_write('h04, 0, 4'hF, -1);
        axi_write('h54, 2, 4'hF, -1);
        axi_write('h0C, 'h20, 4'hF, -1);
        axi_read('h10); chk("t4_masked", irq, 0);
        axi_write('h04, 'h20, 4'hF, -1); chk("t4_irq", irq, 1); chk("t4_id5", irq_id, 5);
        axi_write('h10, 'h20, 4'hF, -1); axi_read('h10);
        axi_write('h00, 3, 4'hF, -1); tick(); chk("t4_irq_off", irq, 0);

        // Error responses and write channel back-pressure
        axi_write('h30, 'hDEAD, 4'hF, -1);
        axi_read('hFC);
        bready = 0; awaddr = 8'h30; awvalid = 1; wdata = 32'h1; wstrb = 4'hF;
        tick(); awvalid = 0; tick(); tick();
        chk("t5_no_b_before_w", bvalid, 0);
        wvalid = 1; tick(); wvalid = 0;
        bq.push_back(2'b10);
        tick();
        for (int i = 0; i < 5; i++) begin
            awvalid = 1;
            chk("t5_bvalid_held", bvalid, 1);
            chk("t5_aw_blocked", awready, 0);
            tick();
        end
        awvalid = 0; b0 = b_cnt; bready = 1;
        tick(); tick(); tick();
        chk("t5_single_b", b_cnt, b0 + 1);

        // Set beats W1C, then asynchronous reset during service
        axi_write('h00, 0, 4'hF, -1);
        axi_write('h08, 'h02, 4'hF, -1);
        axi_write('h44, 3, 4'hF, -1);
        axi_write('h04, 'h02, 4'hF, -1);
        axi_write('h10, 'h02, 4'hF, 'h02);
        axi_read('h10);
        axi_write('h00, 1, 4'hF, -1); tick();
        chk("t6_irq", irq, 1); chk("t6_id1", irq_id, 1);
        #2 aresetn = 0; model_reset(); irq_in = 0;
        #1 chk("t6_rst_irq", irq, 0);
        @(negedge aclk); aresetn = 1;
        axi_read('h00); axi_read('h14);

        // Randomised traffic
        for (int it = 0; it < 300; it++) begin
            int op = $urandom_range(0, 9);
            int k  = $urandom_range(0, N-1);
            bit [3:0] st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if (op <= 2) begin
                if ($urandom_range(0, 1)) irq_in = irq_in ^ N'(1 << k);
                tick();
            end else if (op == 3) axi_write('h00, {30'd0, 1'($urandom), 1'($urandom_range(0, 3) != 0)}, st, -1);
            else if (op == 4) axi_write(4 * $urandom_range(1, 4), $urandom, st, -1);
            else if (op == 5) axi_write('h40 + 4*k, $urandom, st, -1);
            else if (op == 6) axi_write(($urandom_range(0, 3) == 0) ? 4*$urandom_range(6, 15) : 'h00, 3, 4'hF, -1);
            else if (op == 7) axi_read(4 * $urandom_range(0, 5));
            else if (op == 8) axi_read('h40 + 4*k);
            else axi_read($urandom_range(0, 255));
        end
        tick(); tick();
        chk("bq_drained", bq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
